// File: rtl/mac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared constants for the MAC PRBS frame controller: frame
//               state encoding, PRBS source latency and state decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_RESET_SRC = 3'd1;
    localparam state_t c_ST_FILL      = 3'd2;
    localparam state_t c_ST_DRAIN     = 3'd3;
    localparam state_t c_ST_GAP       = 3'd4;

    // Cycles from READ_ENABLE to the matching DATA_OUTPUT_VALID.
    localparam int unsigned c_PRBS_LATENCY = 2;

    // States in which returned valids belong to the current frame.
    function automatic logic in_frame_window(input state_t st);
        return (st == c_ST_FILL) || (st == c_ST_DRAIN);
    endfunction

    // States reported on FRAME_ACTIVE.
    function automatic logic is_frame_active(input state_t st);
        return (st == c_ST_RESET_SRC) || (st == c_ST_FILL) || (st == c_ST_DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_frame_gap_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_frame_gap_timer
// Description : Loadable down-counter with a done flag. Loaded with N on
//               state entry; o_done is high during the Nth cycle (and at once
//               when N is 0 or 1), so a state can exit on o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_frame_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/mac_prbs_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_prbs_frame_ctrl
// Description : Frame sequencer for the MAC PRBS bit source. Reseeds the
//               source each frame, issues FRAME_BITS reads under PHY
//               backpressure, counts returned valids, reports completion and
//               enforces an inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_prbs_frame_ctrl
    import mac_pkg::*;
#(
    parameter int FRAME_BITS    = 1024,
    parameter int RST_CYCLES    = 2,
    parameter int GAP_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT = 8,
    parameter int CNT_W         = 16
) (
    input  logic             SERIAL_CLK,
    input  logic             MAC_RST,
    input  logic             START,
    input  logic             FRAME_REQ,
    input  logic             PHY_READY,
    input  logic             PRBS_VALID,
    output logic             PHY_RST,
    output logic             READ_ENABLE,
    output logic             FRAME_ACTIVE,
    output logic             FRAME_DONE,
    output logic [CNT_W-1:0] FRAME_COUNT,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] c_FRAME_BITS = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] c_LAST_ISSUE = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] c_RST_LOAD   = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] c_GAP_LOAD   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] c_DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_received;
    logic [CNT_W-1:0] w_recv_next;
    logic [CNT_W-1:0] r_frame_count;
    logic [CNT_W-1:0] w_tmr_value;
    logic             r_pending;
    logic             r_err;
    logic             r_frame_done;
    logic             r_phy_rst;
    logic             r_frame_active;
    logic             w_read_en;
    logic             w_valid_ok;
    logic             w_complete;
    logic             w_timeout;
    logic             w_start_frame;
    logic             w_tmr_load;
    logic             w_tmr_done;

    assign w_read_en     = (r_state == c_ST_FILL) && PHY_READY;
    // A valid is counted only inside the frame window and only up to FRAME_BITS.
    assign w_valid_ok    = PRBS_VALID && in_frame_window(r_state) && (r_received < c_FRAME_BITS);
    assign w_recv_next   = r_received + {{(CNT_W-1){1'b0}}, w_valid_ok};
    // Completion looks at the count including this cycle's valid, so the
    // registered FRAME_DONE lands the cycle after the last bit returns.
    assign w_complete    = (r_state == c_ST_DRAIN) && (w_recv_next == c_FRAME_BITS);
    assign w_timeout     = (r_state == c_ST_DRAIN) && !w_complete && w_tmr_done;
    assign w_start_frame = (r_state == c_ST_IDLE) && START && (FRAME_REQ || r_pending);

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_start_frame)                             w_next_state = c_ST_RESET_SRC;
            c_ST_RESET_SRC: if (w_tmr_done)                                w_next_state = c_ST_FILL;
            c_ST_FILL:      if (w_read_en && (r_issued == c_LAST_ISSUE))   w_next_state = c_ST_DRAIN;
            c_ST_DRAIN:     if (w_complete || w_timeout)                   w_next_state = c_ST_GAP;
            c_ST_GAP:       if (w_tmr_done)                                w_next_state = c_ST_IDLE;
            default:                                                       w_next_state = c_ST_IDLE;
        endcase
    end

    // Timer reload value chosen by the state being entered
    always_comb begin
        w_tmr_value = c_DRAIN_LOAD;
        if (w_next_state == c_ST_RESET_SRC) begin
            w_tmr_value = c_RST_LOAD;
        end else if (w_next_state == c_ST_GAP) begin
            w_tmr_value = c_GAP_LOAD;
        end
    end

    assign w_tmr_load = (w_next_state != r_state);

    mac_frame_gap_timer #(
        .W       (CNT_W)
    ) u_timer (
        .clk     (SERIAL_CLK),
        .rst     (MAC_RST),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    // Frame state register
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Issue and receive counters, cleared while the source is being reseeded
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST || (r_state == c_ST_RESET_SRC)) begin
            r_issued   <= '0;
            r_received <= '0;
        end else begin
            if (w_read_en) begin
                r_issued <= r_issued + 1'b1;
            end
            r_received <= w_recv_next;
        end
    end

    // Single-depth request queue; requests seen while one is queued are dropped
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST) begin
            r_pending <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_start_frame) begin
                r_pending <= 1'b0;
            end
        end else if (FRAME_REQ) begin
            r_pending <= 1'b1;
        end
    end

    // Frame completion pulse, completed-frame count and sticky error
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err         <= 1'b0;
        end else begin
            r_frame_done <= w_complete || w_timeout;
            if (w_complete || w_timeout) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (w_timeout || (PRBS_VALID && !w_valid_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Registered state decodes so PHY_RST and FRAME_ACTIVE are glitch-free
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST) begin
            r_phy_rst      <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            r_phy_rst      <= (w_next_state == c_ST_RESET_SRC);
            r_frame_active <= is_frame_active(w_next_state);
        end
    end

    assign PHY_RST      = r_phy_rst;
    assign READ_ENABLE  = w_read_en;
    assign FRAME_ACTIVE = r_frame_active;
    assign FRAME_DONE   = r_frame_done;
    assign FRAME_COUNT  = r_frame_count;
    assign ERR          = r_err;

endmodule
`default_nettype wire
